// File: rtl/leaky_relu_sched_if.sv
// leaky_relu_sched_if: row-stream and array-side bus of the leaky-ReLU pass
// sequencer. slave is the controller view, master the environment view
// (upstream producer, leaky-ReLU array and writeback sink).
interface leaky_relu_sched_if #(
    parameter int N = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*16-1:0]      in_data;
    logic signed [15:0]   lr_leak_factor;
    logic [N-1:0]         lr_valid;
    logic [N*16-1:0]      lr_data;
    logic [N-1:0]         lr_valid_ret;
    logic [N*16-1:0]      lr_data_ret;
    logic                 out_valid;
    logic [N*16-1:0]      out_data;

    modport slave (
        input  in_valid, in_data, lr_valid_ret, lr_data_ret,
        output in_ready, lr_leak_factor, lr_valid, lr_data, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, lr_valid_ret, lr_data_ret,
        input  in_ready, lr_leak_factor, lr_valid, lr_data, out_valid, out_data
    );
endinterface

// File: rtl/leaky_relu_sched.sv
// leaky_relu_sched: sequences one activation pass through an N-column
// leaky-ReLU array. Latches rows and leak factor on start, accepts rows with
// valid/ready, skews columns diagonally into the array and de-skews the
// returned columns into aligned output rows.
// Optional build macro LR_SCHED_CHECK_EN: sticky alignment checker on err;
// without it err is tied low.
module leaky_relu_sched #(
    parameter int N     = 2,
    parameter int ROW_W = 16,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [ROW_W-1:0]   cfg_rows,
    input  logic signed [15:0] cfg_leak,
    output logic               busy,
    output logic               done,
    output logic               err,
    leaky_relu_sched_if.slave  bus
);

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ROW_W-1:0]   rows_q;
    logic [ROW_W-1:0]   acc_cnt;
    logic [ROW_W-1:0]   out_cnt;
    logic [ROW_W-1:0]   acc_cnt_nxt;
    logic [ROW_W-1:0]   out_cnt_nxt;
    logic               accept;
    logic               out_fire;
    logic               start_ok;
    logic [N-1:0]       aligned_vld;
    logic [N*DATA_W-1:0] aligned_dat;

    // Row acceptance is purely a function of state and the accept count.
    assign bus.in_ready = (state == S_RUN) && (acc_cnt < rows_q);
    assign accept       = bus.in_valid && bus.in_ready;
    assign start_ok     = (state == S_IDLE) && cfg_start;

    // out_cnt only counts rows that belong to the current pass, so it never
    // runs past rows_q.
    assign out_fire    = bus.out_valid && ((state == S_RUN) || (state == S_DRAIN))
                         && (out_cnt < rows_q);
    assign acc_cnt_nxt = acc_cnt + {{(ROW_W-1){1'b0}}, accept};
    assign out_cnt_nxt = out_cnt + {{(ROW_W-1){1'b0}}, out_fire};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs; RUN/DRAIN exits look at the post-edge
    // counts so the last accept or last output and the exit share an edge.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (cfg_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = (rows_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (acc_cnt_nxt == rows_q) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_cnt_nxt == rows_q) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pass configuration and row counters; counters restart on each start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q             <= '0;
            bus.lr_leak_factor <= '0;
            acc_cnt            <= '0;
            out_cnt            <= '0;
        end else if (start_ok) begin
            rows_q             <= cfg_rows;
            bus.lr_leak_factor <= cfg_leak;
            acc_cnt            <= '0;
            out_cnt            <= '0;
        end else begin
            acc_cnt <= acc_cnt_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_col
        localparam int DESKEW = N - 1 - i;

        logic [i:0]               vld_p;
        logic signed [DATA_W-1:0] dat_p [i+1];

        // Skew line: column i reaches the array i+1 cycles after its accept;
        // data is forced to zero for non-accepted cycles.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_p <= '0;
                for (int k = 0; k <= i; k++) dat_p[k] <= '0;
            end else begin
                vld_p[0] <= accept;
                dat_p[0] <= accept ? bus.in_data[DATA_W*i +: DATA_W] : '0;
                for (int k = 1; k <= i; k++) begin
                    vld_p[k] <= vld_p[k-1];
                    dat_p[k] <= dat_p[k-1];
                end
            end
        end

        assign bus.lr_valid[i]                  = vld_p[i];
        assign bus.lr_data[DATA_W*i +: DATA_W]  = dat_p[i];

        if (DESKEW == 0) begin : g_direct
            assign aligned_vld[i]                   = bus.lr_valid_ret[i];
            assign aligned_dat[DATA_W*i +: DATA_W]  = bus.lr_data_ret[DATA_W*i +: DATA_W];
        end else begin : g_deskew
            logic [DESKEW-1:0]        dvld_p;
            logic signed [DATA_W-1:0] ddat_p [DESKEW];

            // De-skew line: earlier columns wait for the last column to return.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dvld_p <= '0;
                    for (int k = 0; k < DESKEW; k++) ddat_p[k] <= '0;
                end else begin
                    dvld_p[0] <= bus.lr_valid_ret[i];
                    ddat_p[0] <= bus.lr_data_ret[DATA_W*i +: DATA_W];
                    for (int k = 1; k < DESKEW; k++) begin
                        dvld_p[k] <= dvld_p[k-1];
                        ddat_p[k] <= ddat_p[k-1];
                    end
                end
            end

            assign aligned_vld[i]                  = dvld_p[DESKEW-1];
            assign aligned_dat[DATA_W*i +: DATA_W] = ddat_p[DESKEW-1];
        end
    end

    assign bus.out_valid = &aligned_vld;
    assign bus.out_data  = bus.out_valid ? aligned_dat : '0;

`ifdef LR_SCHED_CHECK_EN
    // Sticky error: columns returned out of alignment, or an output row
    // beyond the pass row count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (((aligned_vld != '0) && (aligned_vld != '1)) ||
                     (bus.out_valid && ((state == S_RUN) || (state == S_DRAIN)) &&
                      (out_cnt == rows_q))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_leaky_relu_sched.sv
// tb_leaky_relu_sched: directed bench for leaky_relu_sched (N=2, LAT=1).
// The array is modelled as a one-cycle register that returns the bitwise
// inverse of each column, with an optional one-cycle extra delay on column 1.
module tb_leaky_relu_sched;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_rows;
    logic signed [15:0] cfg_leak;
    logic        busy;
    logic        done;
    logic        err;
    logic        late1;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef LR_SCHED_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    leaky_relu_sched_if #(.N(2)) bus ();

    leaky_relu_sched #(.N(2), .ROW_W(16), .LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_rows  (cfg_rows),
        .cfg_leak  (cfg_leak),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model
    logic [1:0]  ret_vld;
    logic        ret_vld1_dly;
    logic [31:0] ret_dat;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_vld      <= '0;
            ret_vld1_dly <= 1'b0;
            ret_dat      <= '0;
        end else begin
            ret_vld      <= bus.lr_valid;
            ret_vld1_dly <= ret_vld[1];
            ret_dat      <= ~bus.lr_data;
        end
    end

    assign bus.lr_valid_ret = {(late1 ? ret_vld1_dly : ret_vld[1]), ret_vld[0]};
    assign bus.lr_data_ret  = ret_dat;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; cfg_start = 1'b0; cfg_rows = '0; cfg_leak = '0; late1 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        tick; tick;
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_ready",  bus.in_ready, 0);
        chk("rst_oval",   bus.out_valid, 0);
        chk("rst_lrval",  bus.lr_valid, 0);
        chk("rst_leak",   bus.lr_leak_factor, 0);
        chk("rst_err",    err, 0);
        rst = 1'b1;
        tick;

        // Three back-to-back rows, plus an ignored start while busy
        cfg_start = 1'b1; cfg_rows = 16'd3; cfg_leak = 16'h0040;
        tick;
        cfg_start = 1'b0;
        chk("t1_load_busy",  busy, 1);
        chk("t1_load_ready", bus.in_ready, 0);
        chk("t1_leak",       bus.lr_leak_factor, 32'h0040);
        bus.in_valid = 1'b1; bus.in_data = 32'h0011_0010;
        tick;
        chk("t1_run_ready",  bus.in_ready, 1);
        tick;
        chk("t1_c1_lrval",   bus.lr_valid, 2'b01);
        chk("t1_c1_lrdat",   bus.lr_data, 32'h0000_0010);
        chk("t1_c1_oval",    bus.out_valid, 0);
        bus.in_data = 32'h0021_0020;
        cfg_start = 1'b1; cfg_rows = 16'd5; cfg_leak = 16'h1234;
        tick;
        cfg_start = 1'b0;
        chk("t1_c2_lrval",   bus.lr_valid, 2'b11);
        chk("t1_c2_lrdat",   bus.lr_data, 32'h0011_0020);
        chk("t1_c2_leak",    bus.lr_leak_factor, 32'h0040);
        chk("t1_c2_oval",    bus.out_valid, 0);
        bus.in_data = 32'h0031_0030;
        tick;
        chk("t1_c3_ready",   bus.in_ready, 0);
        chk("t1_c3_lrval",   bus.lr_valid, 2'b11);
        chk("t1_c3_lrdat",   bus.lr_data, 32'h0021_0030);
        chk("t1_c3_oval",    bus.out_valid, 1);
        chk("t1_c3_odat",    bus.out_data, 32'hFFEE_FFEF);
        bus.in_valid = 1'b0; bus.in_data = '0;
        tick;
        chk("t1_c4_lrval",   bus.lr_valid, 2'b10);
        chk("t1_c4_lrdat",   bus.lr_data, 32'h0031_0000);
        chk("t1_c4_oval",    bus.out_valid, 1);
        chk("t1_c4_odat",    bus.out_data, 32'hFFDE_FFDF);
        chk("t1_c4_done",    done, 0);
        tick;
        chk("t1_c5_lrval",   bus.lr_valid, 2'b00);
        chk("t1_c5_oval",    bus.out_valid, 1);
        chk("t1_c5_odat",    bus.out_data, 32'hFFCE_FFCF);
        chk("t1_c5_done",    done, 0);
        tick;
        chk("t1_c6_done",    done, 1);
        chk("t1_c6_busy",    busy, 1);
        chk("t1_c6_oval",    bus.out_valid, 0);
        chk("t1_c6_odat",    bus.out_data, 0);
        tick;
        chk("t1_c7_done",    done, 0);
        chk("t1_c7_busy",    busy, 0);
        chk("t1_c7_leak",    bus.lr_leak_factor, 32'h0040);

        // Zero-row pass
        cfg_start = 1'b1; cfg_rows = 16'd0; cfg_leak = 16'h0055;
        tick;
        cfg_start = 1'b0;
        chk("t2_load_busy",  busy, 1);
        chk("t2_load_ready", bus.in_ready, 0);
        chk("t2_load_done",  done, 0);
        chk("t2_leak",       bus.lr_leak_factor, 32'h0055);
        tick;
        chk("t2_done",       done, 1);
        chk("t2_ready",      bus.in_ready, 0);
        chk("t2_oval",       bus.out_valid, 0);
        tick;
        chk("t2_idle_done",  done, 0);
        chk("t2_idle_busy",  busy, 0);

        // Reset in DRAIN with two rows in flight
        cfg_start = 1'b1; cfg_rows = 16'd2; cfg_leak = 16'h0077;
        tick;
        cfg_start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h0102_0101;
        tick;
        tick;
        bus.in_data = 32'h0202_0201;
        tick;
        bus.in_valid = 1'b0; bus.in_data = '0;
        chk("t4_drain_busy",  busy, 1);
        chk("t4_drain_ready", bus.in_ready, 0);
        chk("t4_drain_lrval", bus.lr_valid, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_busy",   busy, 0);
        chk("t4_rst_lrval",  bus.lr_valid, 0);
        chk("t4_rst_lrdat",  bus.lr_data, 0);
        chk("t4_rst_oval",   bus.out_valid, 0);
        chk("t4_rst_odat",   bus.out_data, 0);
        chk("t4_rst_leak",   bus.lr_leak_factor, 0);
        chk("t4_rst_done",   done, 0);
        tick;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("t4_post_oval", bus.out_valid, 0);
            chk("t4_post_done", done, 0);
        end

        // Upstream gaps (1,0,0,1) with two rows
        cfg_start = 1'b1; cfg_rows = 16'd2; cfg_leak = 16'h0033;
        tick;
        cfg_start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h8000_7FFF;
        tick;
        chk("t3_run_ready",  bus.in_ready, 1);
        tick;
        bus.in_valid = 1'b0; bus.in_data = 32'hDEAD_BEEF;
        chk("t3_a1_oval",    bus.out_valid, 0);
        chk("t3_a1_lrval",   bus.lr_valid, 2'b01);
        chk("t3_a1_lrdat",   bus.lr_data, 32'h0000_7FFF);
        tick;
        chk("t3_a2_oval",    bus.out_valid, 0);
        chk("t3_a2_ready",   bus.in_ready, 1);
        chk("t3_a2_lrdat",   bus.lr_data, 32'h8000_0000);
        tick;
        chk("t3_a3_oval",    bus.out_valid, 1);
        chk("t3_a3_odat",    bus.out_data, 32'h7FFF_8000);
        bus.in_valid = 1'b1; bus.in_data = 32'hFFFF_0000;
        tick;
        bus.in_valid = 1'b0; bus.in_data = '0;
        chk("t3_a4_oval",    bus.out_valid, 0);
        chk("t3_a4_ready",   bus.in_ready, 0);
        tick;
        chk("t3_a5_oval",    bus.out_valid, 0);
        tick;
        chk("t3_a6_oval",    bus.out_valid, 1);
        chk("t3_a6_odat",    bus.out_data, 32'h0000_FFFF);
        chk("t3_a6_done",    done, 0);
        tick;
        chk("t3_a7_done",    done, 1);
        tick;
        chk("t3_a8_busy",    busy, 0);

        // Column 1 returned one cycle late
        late1 = 1'b1;
        cfg_start = 1'b1; cfg_rows = 16'd1; cfg_leak = 16'h0100;
        tick;
        cfg_start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h0005_0004;
        tick;
        tick;
        bus.in_valid = 1'b0; bus.in_data = '0;
        tick;
        tick;
        chk("t5_i3_oval",    bus.out_valid, 0);
        chk("t5_i3_err",     err, 0);
        tick;
        chk("t5_i4_oval",    bus.out_valid, 0);
        chk("t5_i4_err",     err, EXP_ERR);
        tick; tick; tick;
        chk("t5_hold_err",   err, EXP_ERR);
        chk("t5_hold_busy",  busy, 1);
        chk("t5_hold_leak",  bus.lr_leak_factor, 32'h0100);
        rst = 1'b0;
        #1;
        chk("t5_rst_err",    err, 0);
        chk("t5_rst_busy",   busy, 0);
        tick;
        rst = 1'b1; late1 = 1'b0;
        tick;
        chk("t5_post_err",   err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/leaky_relu_sched.md
Name: leaky_relu_sched

Overview:
- Sequences one activation pass through the N-column leaky-ReLU array.
- Latches the leak factor for the pass and accepts row vectors from upstream with a valid/ready handshake.
- Skews each row diagonally into the array (column i one cycle later than column i-1). De-skews the returned columns so each output row is column-aligned.
- Counts rows in and out, reports busy, and pulses done at the end of the pass.
- Sits between the systolic-array result path and the unified buffer writeback.

Parameters:
- N, 2, number of columns; matches the attached leaky-ReLU array.
- ROW_W, 16, width of the row-count field.
- LAT, 1, fixed latency of each leaky-ReLU column in cycles, valid in to valid out.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pass start; honoured only in IDLE.
- cfg_rows  in  ROW_W  rows in the pass; sampled with cfg_start.
- cfg_leak  in  16  signed leak factor; sampled with cfg_start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  controller can accept a row.
- in_data  in  N*16  signed row; column i at bits [16i+15:16i].
- lr_leak_factor  out  16  leak factor to the array; held constant for the whole pass.
- lr_valid  out  N  per-column valid to the array, skewed.
- lr_data  out  N*16  per-column data to the array, skewed.
- lr_valid_ret  in  N  per-column valid from the array.
- lr_data_ret  in  N*16  per-column data from the array.
- out_valid  out  1  aligned output row valid; no backpressure.
- out_data  out  N*16  aligned output row.
- err  out  1  sticky alignment error; see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous): the following are all cleared, effective immediately:
  - state to IDLE;
  - both counters, all skew and de-skew registers;
  - lr_leak_factor;
  - every output, including err.
- Reset mid-pass discards all in-flight rows; no done is issued.
- FSM states:
  - IDLE: cfg_start=1 latches cfg_rows into rows_q and cfg_leak into lr_leak_factor, then goes to LOAD.
  - LOAD: one cycle. If rows_q==0, go to DONE; otherwise go to RUN.
  - RUN: in_ready = (acc_cnt < rows_q). When acc_cnt reaches rows_q, go to DRAIN.
  - DRAIN: in_ready=0. When out_cnt==rows_q, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- cfg_start outside IDLE is ignored. lr_leak_factor changes only on an IDLE start.
- Accept: an edge with in_valid && in_ready increments acc_cnt; in_ready is combinational from state and acc_cnt.
- Skew: column i of an accepted row appears on lr_valid[i]/lr_data[i] exactly 1+i cycles after the accepting edge. lr_data is 0 whenever lr_valid is 0.
- De-skew: returned column i passes through N-1-i registers. out_valid is the AND of the aligned column valids. out_data is the aligned data, 0 when out_valid is 0.
- Latency: out_valid for a row is high exactly N+LAT cycles after its accepting edge (N=2, LAT=1 gives 3).
- Throughput: one row per cycle; back-to-back rows produce back-to-back output.
- out_cnt increments on each out_valid cycle.
- Counters are ROW_W wide and never wrap: acc_cnt is capped by rows_q, and out_cnt by the row count in flight.
- If acceptance and emission of the final row land on the same edge, both counters update on that edge. A DRAIN exit and the last out_valid on the same edge are legal.
- Data is passed through unmodified; the controller performs no arithmetic on data.

Optional Feature:
- Macro: LR_SCHED_CHECK_EN.
- Defined:
  - Every cycle, the N aligned column valids must be all-0 or all-1. Any mismatch sets err, which stays set until reset.
  - During DRAIN and RUN, an out_valid when out_cnt==rows_q also sets err.
- Undefined: the check logic is absent and err is tied to 0.

Test Plan:
- Reset, then cfg_start with rows=3, leak=0x0040, N=2, rows fed back-to-back:
  - lr_valid[0] high at cycles 1–3 after the first accept and lr_valid[1] at cycles 2–4;
  - out_valid high 3 cycles after each accept;
  - done pulses one cycle after the third output;
  - lr_leak_factor=0x0040 throughout.
- cfg_rows=0 -> sequence IDLE→LOAD→DONE; done 2 cycles after start; in_ready never high; no out_valid.
- Upstream gaps (in_valid 1,0,0,1 pattern) with rows=2 -> outputs appear at accept+3 with a matching gap; out_data equals the per-column returned data, aligned.
- cfg_start with leak=0x1234 while busy -> ignored; lr_leak_factor unchanged; pass count unaffected.
- rst asserted low mid-DRAIN with 2 rows in flight -> all outputs 0 immediately; no out_valid or done afterward; the next start works normally.
- With LR_SCHED_CHECK_EN, drive a corrupted lr_valid_ret[1] one cycle late -> err set and stays 1 until reset. Without the macro, err stays 0.
